// File: rtl/flag_pkg.sv
// Flag-group types shared by the control unit, the execute conditional logic
// and the decode-side flag hazard unit.
package flag_pkg;

    localparam int FLAG_NZ = 1;
    localparam int FLAG_CV = 0;

    typedef logic [1:0] flag_grp_t;

    localparam flag_grp_t FLAG_NONE = 2'b00;

    function automatic logic grp_overlap(input flag_grp_t a, input flag_grp_t b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/flag_pending_pipe.sv
// Shift register of in-flight flag writers from Decode issue to flag commit.
// Stage 0 is the writer in Execute; the entry leaving the last stage has committed.
module flag_pending_pipe
    import flag_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_en,
    input  flag_grp_t i_ins,
    output flag_grp_t o_pend_mask
);

    logic [DEPTH*2-1:0] w_stages;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            flag_grp_t r_stage;
            flag_grp_t w_in;

            if (gi == 0) begin : g_head
                assign w_in = i_ins;
            end else begin : g_body
                assign w_in = w_stages[(gi-1)*2 +: 2];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stage <= FLAG_NONE;
                end else if (i_en) begin
                    r_stage <= w_in;
                end
            end

            assign w_stages[gi*2 +: 2] = r_stage;
        end
    endgenerate

    always_comb begin
        o_pend_mask = FLAG_NONE;
        for (int i = 0; i < DEPTH; i++) begin
            o_pend_mask = o_pend_mask | w_stages[i*2 +: 2];
        end
    end

endmodule

// File: rtl/flag_hazard_unit.sv
// Decode-side flag hazard unit: stalls a flag reader until all older writers of
// the groups it reads have committed, and produces the matching flushes.
module flag_hazard_unit
    import flag_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid_d,
    input  flag_grp_t        i_flag_read_d,
    input  flag_grp_t        i_flag_write_d,
    input  logic             i_branch_taken_e,
    input  logic             i_stall_ext,
    output logic             o_stall_d,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output flag_grp_t        o_pending_flags,
    output logic [CNT_W-1:0] o_stall_count
);

    flag_grp_t        w_pend_mask;
    flag_grp_t        w_ins;
    logic             w_haz;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_stall_count_next;

    // The Decode instruction's own writes are not in the pending mask yet,
    // so a read-and-write instruction sees the old flags without stalling.
    assign w_haz   = i_valid_d & grp_overlap(i_flag_read_d, w_pend_mask);
    assign w_stall = w_haz & ~i_branch_taken_e;

    // A squashed or stalled Decode instruction enters Execute as a bubble.
    assign w_ins = (i_valid_d & ~w_stall & ~i_branch_taken_e) ? i_flag_write_d : FLAG_NONE;

    flag_pending_pipe #(
        .DEPTH (DEPTH)
    ) u_pend (
        .clk         (clk),
        .rst         (rst),
        .i_en        (~i_stall_ext),
        .i_ins       (w_ins),
        .o_pend_mask (w_pend_mask)
    );

    always_comb begin
        r_stall_count_next = r_stall_count;
        if (!i_stall_ext && w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count_next = r_stall_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else begin
            r_stall_count <= r_stall_count_next;
        end
    end

    assign o_stall_d       = w_stall;
    assign o_flush_d       = i_branch_taken_e;
    assign o_flush_e       = w_stall | i_branch_taken_e;
    assign o_pending_flags = w_pend_mask;
    assign o_stall_count   = r_stall_count;

endmodule

// File: tb/tb_flag_hazard_unit.sv
// Self-checking bench: three configurations share one stimulus stream and are
// compared every cycle against a lifetime-based model of in-flight writers.
module tb_flag_hazard_unit;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_d = 1'b0;
    logic [1:0] rd_d = 2'b00;
    logic [1:0] wr_d = 2'b00;
    logic       br_e = 1'b0;
    logic       stall_ext = 1'b0;

    logic        stall_o [NDUT];
    logic        flushd_o[NDUT];
    logic        flushe_o[NDUT];
    logic [1:0]  pend_o  [NDUT];
    logic [15:0] cnt_o   [NDUT];
    logic [1:0]  cnt2_w;

    always #5 clk = ~clk;

    flag_hazard_unit #(.DEPTH(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .i_valid_d(valid_d), .i_flag_read_d(rd_d),
        .i_flag_write_d(wr_d), .i_branch_taken_e(br_e), .i_stall_ext(stall_ext),
        .o_stall_d(stall_o[0]), .o_flush_d(flushd_o[0]), .o_flush_e(flushe_o[0]),
        .o_pending_flags(pend_o[0]), .o_stall_count(cnt_o[0]));

    flag_hazard_unit #(.DEPTH(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .i_valid_d(valid_d), .i_flag_read_d(rd_d),
        .i_flag_write_d(wr_d), .i_branch_taken_e(br_e), .i_stall_ext(stall_ext),
        .o_stall_d(stall_o[1]), .o_flush_d(flushd_o[1]), .o_flush_e(flushe_o[1]),
        .o_pending_flags(pend_o[1]), .o_stall_count(cnt_o[1]));

    flag_hazard_unit #(.DEPTH(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .i_valid_d(valid_d), .i_flag_read_d(rd_d),
        .i_flag_write_d(wr_d), .i_branch_taken_e(br_e), .i_stall_ext(stall_ext),
        .o_stall_d(stall_o[2]), .o_flush_d(flushd_o[2]), .o_flush_e(flushe_o[2]),
        .o_pending_flags(pend_o[2]), .o_stall_count(cnt2_w));

    assign cnt_o[2] = {14'b0, cnt2_w};

    // Model: each issued writer lives for DEPTH clock edges after it enters Execute.
    int          m_depth[NDUT] = '{1, 3, 2};
    int          m_cap  [NDUT] = '{65535, 65535, 3};
    int          m_life [NDUT][8];
    logic [1:0]  m_grp  [NDUT][8];
    int          m_cnt  [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, d, $time, act, exp);
    endtask

    function automatic logic [1:0] model_pend(input int d);
        logic [1:0] m = 2'b00;
        for (int k = 0; k < 8; k++) if (m_life[d][k] > 0) m = m | m_grp[d][k];
        return m;
    endfunction

    function automatic logic model_stall(input int d);
        return valid_d && ((rd_d & model_pend(d)) != 2'b00) && !br_e;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) m_life[d][k] = 0;
                m_cnt[d] = 0;
            end else if (!stall_ext) begin
                logic s;
                s = model_stall(d);
                for (int k = 0; k < 8; k++) if (m_life[d][k] > 0) m_life[d][k]--;
                if (valid_d && !s && !br_e && wr_d != 2'b00) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_life[d][k] == 0) begin
                            m_life[d][k] = m_depth[d];
                            m_grp[d][k]  = wr_d;
                            break;
                        end
                    end
                end
                if (s && m_cnt[d] < m_cap[d]) m_cnt[d]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            logic s;
            s = model_stall(d);
            chk("stall_d", d, int'(stall_o[d]), int'(s));
            chk("flush_d", d, int'(flushd_o[d]), int'(br_e));
            chk("flush_e", d, int'(flushe_o[d]), int'(s | br_e));
            chk("pending", d, int'(pend_o[d]), int'(model_pend(d)));
            chk("count", d, int'(cnt_o[d]), m_cnt[d]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] r, input logic [1:0] w,
                         input logic b, input logic x);
        valid_d = v; rd_d = r; wr_d = w; br_e = b; stall_ext = x;
    endtask

    initial begin
        int c0, c1;
        step(); step();
        rst = 1'b0;

        // Writer NZ then reader NZ: DEPTH=1 stalls once, DEPTH=3 stalls three times.
        drive(1, 2'b00, 2'b10, 0, 0); step();
        drive(1, 2'b10, 2'b00, 0, 0); #1;
        chk("lit_stall_t1", 0, int'(stall_o[0]), 1);
        chk("lit_flushe_t1", 0, int'(flushe_o[0]), 1);
        chk("lit_stall_t1", 1, int'(stall_o[1]), 1);
        step();
        chk("lit_stall_t2", 0, int'(stall_o[0]), 0);
        chk("lit_count_t2", 0, int'(cnt_o[0]), 1);
        chk("lit_stall_t2", 1, int'(stall_o[1]), 1);
        step();
        chk("lit_stall_t3", 1, int'(stall_o[1]), 1);
        step();
        chk("lit_stall_t4", 1, int'(stall_o[1]), 0);
        chk("lit_count_t4", 1, int'(cnt_o[1]), 3);
        chk("lit_count_t4", 2, int'(cnt_o[2]), 2);

        // Writer CV then reader NZ: disjoint groups never stall.
        drive(1, 2'b00, 2'b01, 0, 0); step();
        drive(1, 2'b10, 2'b00, 0, 0); #1;
        chk("lit_nooverlap", 0, int'(stall_o[0]), 0);
        chk("lit_nooverlap", 1, int'(stall_o[1]), 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        step(); step(); step();

        // Branch and hazard together: branch wins, bubble inserted.
        drive(1, 2'b00, 2'b10, 0, 0); step();
        drive(1, 2'b10, 2'b01, 1, 0); #1;
        chk("lit_br_stall", 0, int'(stall_o[0]), 0);
        chk("lit_br_flushd", 0, int'(flushd_o[0]), 1);
        chk("lit_br_flushe", 0, int'(flushe_o[0]), 1);
        step();
        drive(0, 2'b00, 2'b00, 0, 0); #1;
        chk("lit_br_pend", 0, int'(pend_o[0]), 0);
        chk("lit_br_pend", 1, int'(pend_o[1]), 2);
        step(); step(); step();

        // Freeze during a hazard, then saturate the 2-bit counter.
        drive(1, 2'b00, 2'b10, 0, 0); step();
        drive(1, 2'b10, 2'b00, 0, 1); #1;
        c0 = int'(cnt_o[0]); c1 = int'(cnt_o[1]);
        step(); step(); step(); step();
        chk("lit_frz_count", 0, int'(cnt_o[0]), c0);
        chk("lit_frz_count", 1, int'(cnt_o[1]), c1);
        chk("lit_frz_pend", 0, int'(pend_o[0]), 2);
        chk("lit_frz_stall", 0, int'(stall_o[0]), 1);
        stall_ext = 1'b0;
        step(); step(); step();
        chk("lit_sat", 2, int'(cnt_o[2]), 3);

        // Async reset mid-stall with pend[0]=NZ.
        drive(1, 2'b00, 2'b10, 0, 0); step();
        drive(1, 2'b10, 2'b00, 0, 0); #1;
        chk("lit_pre_rst", 0, int'(stall_o[0]), 1);
        rst = 1'b1; #1;
        chk("lit_rst_stall", 0, int'(stall_o[0]), 0);
        chk("lit_rst_flushe", 0, int'(flushe_o[0]), 0);
        chk("lit_rst_pend", 0, int'(pend_o[0]), 0);
        chk("lit_rst_count", 0, int'(cnt_o[0]), 0);
        chk("lit_rst_count", 1, int'(cnt_o[1]), 0);
        step();
        rst = 1'b0;

        // Randomized traffic with occasional freezes, branches and resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
            end
            step();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
